// File: rtl/slot_pkg.sv
// Shared slot-machine definitions: symbol width, reel count, spin FSM states.
// Used by reel_spin_controller and by the downstream calculate_result block.
package slot_pkg;

  localparam int SYMBOL_W  = 3;
  localparam int NUM_REELS = 3;

  typedef logic [SYMBOL_W-1:0] symbol_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPIN_ALL = 3'd1,
    ST_SPIN_23  = 3'd2,
    ST_SPIN_3   = 3'd3,
    ST_RESULT   = 3'd4
  } slot_state_e;

  function automatic logic is_spin_state(input slot_state_e s);
    return (s == ST_SPIN_ALL) || (s == ST_SPIN_23) || (s == ST_SPIN_3);
  endfunction

endpackage

// File: rtl/reel_spin_controller_reel_counter.sv
// One reel: a 3-bit symbol that advances by STEP (mod 8) on each enabled cycle.
module reel_counter
  import slot_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    enable,
  output symbol_t symbol
);

  symbol_t symbol_q, symbol_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    symbol_d = symbol_q;
    if (enable) symbol_d = symbol_q + SYMBOL_W'(STEP);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) symbol_q <= '0;
    else        symbol_q <= symbol_d;
  end

  assign symbol = symbol_q;

endmodule

// File: rtl/reel_spin_controller.sv
// Three-reel spin controller: tick divider, stop sequencing FSM, result pulse.
// Optional auto-stop after AUTO_STOP_TICKS idle ticks when SLOT_AUTO_STOP_EN is defined.
module reel_spin_controller
  import slot_pkg::*;
#(
  parameter int TICK_DIV = 2500000,
  parameter int STEP_1   = 1,
  parameter int STEP_2   = 3,
  parameter int STEP_3   = 5
`ifdef SLOT_AUTO_STOP_EN
  ,
  parameter int AUTO_STOP_TICKS = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spin,
  input  logic                 stop,
  output logic [SYMBOL_W-1:0]  card_1,
  output logic [SYMBOL_W-1:0]  card_2,
  output logic [SYMBOL_W-1:0]  card_3,
  output logic                 spinning,
  output logic [NUM_REELS-1:0] reel_stopped,
  output logic                 result_valid
);

  localparam int             CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  slot_state_e          state_q, state_d;
  logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [NUM_REELS-1:0] reel_stopped_q, reel_stopped_d;
  logic                 spinning_q, spinning_d;
  logic                 tick;
  logic                 stop_req;
  logic [NUM_REELS-1:0] reel_en;

  assign tick = is_spin_state(state_q) && (tick_cnt_q == TICK_LAST);

`ifdef SLOT_AUTO_STOP_EN
  localparam int              IDLE_W    = $clog2(AUTO_STOP_TICKS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(AUTO_STOP_TICKS - 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  // The tick that would bring the idle count to AUTO_STOP_TICKS acts as the stop.
  assign stop_req = stop | (tick && (idle_cnt_q == IDLE_LAST));

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (!is_spin_state(state_q) || stop_req) idle_cnt_d = '0;
    else if (tick)                           idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end
`else
  assign stop_req = stop;
`endif

  always_comb begin
    state_d        = state_q;
    reel_stopped_d = reel_stopped_q;
    spinning_d     = spinning_q;
    result_valid   = 1'b0;
    case (state_q)
      ST_IDLE: if (spin) begin
        state_d        = ST_SPIN_ALL;
        reel_stopped_d = 3'b000;
        spinning_d     = 1'b1;
      end
      ST_SPIN_ALL: if (stop_req) begin
        state_d        = ST_SPIN_23;
        reel_stopped_d = 3'b001;
      end
      ST_SPIN_23: if (stop_req) begin
        state_d        = ST_SPIN_3;
        reel_stopped_d = 3'b011;
      end
      ST_SPIN_3: if (stop_req) begin
        state_d        = ST_RESULT;
        reel_stopped_d = 3'b111;
        spinning_d     = 1'b0;
      end
      ST_RESULT: begin
        result_valid = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter only runs while staying inside the spin states; entry and exit clear it.
  always_comb begin
    tick_cnt_d = '0;
    if (is_spin_state(state_q) && is_spin_state(state_d))
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      tick_cnt_q     <= '0;
      reel_stopped_q <= 3'b111;
      spinning_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      reel_stopped_q <= reel_stopped_d;
      spinning_q     <= spinning_d;
    end
  end

  // Using the next-cycle stopped mask keeps a reel frozen on the tick it is stopped.
  assign reel_en = {NUM_REELS{tick}} & ~reel_stopped_d;

  reel_counter #(.STEP(STEP_1)) u_reel_1 (.clk(clk), .rst_n(rst_n), .enable(reel_en[0]), .symbol(card_1));
  reel_counter #(.STEP(STEP_2)) u_reel_2 (.clk(clk), .rst_n(rst_n), .enable(reel_en[1]), .symbol(card_2));
  reel_counter #(.STEP(STEP_3)) u_reel_3 (.clk(clk), .rst_n(rst_n), .enable(reel_en[2]), .symbol(card_3));

  assign spinning     = spinning_q;
  assign reel_stopped = reel_stopped_q;

endmodule

// File: tb/tb_reel_spin_controller.sv
// Self-checking bench for reel_spin_controller with TICK_DIV=4; covers the
// SLOT_AUTO_STOP_EN build (AUTO_STOP_TICKS=2) when that macro is defined.
module tb_reel_spin_controller;

  localparam int TDIV  = 4;
  localparam int ASTOP = 2;
  localparam int STEPS [3] = '{1, 3, 5};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spin = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] card_1, card_2, card_3;
  logic       spinning;
  logic [2:0] reel_stopped;
  logic       result_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  reel_spin_controller #(
    .TICK_DIV(TDIV), .STEP_1(1), .STEP_2(3), .STEP_3(5)
`ifdef SLOT_AUTO_STOP_EN
    , .AUTO_STOP_TICKS(ASTOP)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .spin(spin), .stop(stop),
    .card_1(card_1), .card_2(card_2), .card_3(card_3),
    .spinning(spinning), .reel_stopped(reel_stopped), .result_valid(result_valid)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a spin is "active" with n reels stopped so far; ticks
  // come every TDIV cycles of activity; a result cycle follows the third stop.
  bit m_active, m_result, m_tk, m_stp;
  int m_nstop, m_tcnt, m_idle;
  int m_card [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_result = 0; m_nstop = 3; m_tcnt = 0; m_idle = 0;
      for (int i = 0; i < 3; i++) m_card[i] = 0;
    end else if (m_result) begin
      m_result = 0;
    end else if (!m_active) begin
      if (spin) begin
        m_active = 1; m_nstop = 0; m_tcnt = 0; m_idle = 0;
      end
    end else begin
      m_tk   = (m_tcnt == TDIV - 1);
      m_tcnt = (m_tcnt + 1) % TDIV;
      m_stp  = stop;
`ifdef SLOT_AUTO_STOP_EN
      if (m_tk && (m_idle + 1 == ASTOP)) m_stp = 1;
`endif
      for (int i = 0; i < 3; i++)
        if (m_tk && i >= m_nstop && !(m_stp && i == m_nstop))
          m_card[i] = (m_card[i] + STEPS[i]) % 8;
      if (m_stp)     m_idle = 0;
      else if (m_tk) m_idle++;
      if (m_stp) begin
        m_nstop++;
        if (m_nstop == 3) begin m_active = 0; m_result = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("card_1", card_1, m_card[0]);
      check("card_2", card_2, m_card[1]);
      check("card_3", card_3, m_card[2]);
      check("spinning", spinning, m_active);
      check("reel_stopped", reel_stopped, m_active ? ((1 << m_nstop) - 1) : 7);
      check("result_valid", result_valid, m_result);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_mid_cycle();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst card_1", card_1, 0);
    check("rst card_2", card_2, 0);
    check("rst card_3", card_3, 0);
    check("rst reel_stopped", reel_stopped, 3'b111);
    check("rst spinning", spinning, 0);
    check("rst result_valid", result_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int pulses;

  initial begin
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    check("idle reel_stopped", reel_stopped, 3'b111);

`ifdef SLOT_AUTO_STOP_EN
    spin = 1'b1; cycles(1); spin = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      if (result_valid) pulses++;
    end
    check("auto pulses", pulses, 1);
    check("auto card_1", card_1, 1);
    check("auto card_2", card_2, 1);
    check("auto card_3", card_3, 1);
    spin = 1'b1; cycles(1); spin = 1'b0;
    cycles(10);
    reset_mid_cycle();
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      cycles(1);
      if (result_valid) pulses++;
    end
    check("abort pulses", pulses, 0);
`else
    spin = 1'b1; cycles(1); spin = 1'b0;
    cycles(8);
    check("2tick card_1", card_1, 2);
    check("2tick card_2", card_2, 6);
    check("2tick card_3", card_3, 2);
    cycles(24);
    check("wrap card_1", card_1, 0);
    check("wrap card_2", card_2, 0);
    check("wrap card_3", card_3, 0);
    cycles(3);
    stop = 1'b1; cycles(1); stop = 1'b0;
    check("coll card_1", card_1, 0);
    check("coll card_2", card_2, 3);
    check("coll card_3", card_3, 5);
    check("coll reel_stopped", reel_stopped, 3'b001);
    spin = 1'b1; cycles(1); spin = 1'b0;
    check("ign spin reel_stopped", reel_stopped, 3'b001);
    check("ign spin spinning", spinning, 1);
    stop = 1'b1; cycles(2); stop = 1'b0;
    check("result pulse", result_valid, 1);
    check("result reel_stopped", reel_stopped, 3'b111);
    check("result card_2", card_2, 3);
    cycles(1);
    check("result one cycle", result_valid, 0);
    stop = 1'b1; cycles(1); stop = 1'b0;
    check("idle stop reel_stopped", reel_stopped, 3'b111);
    spin = 1'b1; stop = 1'b1; cycles(1); spin = 1'b0; stop = 1'b0;
    check("spin+stop reel_stopped", reel_stopped, 3'b000);
    check("spin+stop spinning", spinning, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      spin = ($urandom_range(0, 11) == 0);
      stop = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
      end else begin
        cycles(1);
      end
    end
    spin = 1'b0;
    stop = 1'b0;
    spin = 1'b1; cycles(1); spin = 1'b0;
    cycles(5);
    reset_mid_cycle();
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reel_spin_controller.md
Name: reel_spin_controller

Overview:
- Upstream of calculate_result: generates the three 3-bit symbols card_1..card_3 that calculate_result maps to a multiplier.
- After a spin request, three reels advance at a divided tick rate with different per-reel step sizes.
- Successive stop pulses freeze reel 1, then reel 2, then reel 3.
- When the last reel stops, emits a one-cycle result_valid; downstream payout logic samples the multiplier on that pulse.

Parameters:
- TICK_DIV, 2500000: clock cycles per reel advance; legal range ≥2.
- STEP_1, 1: reel 1 increment per tick, modulo 8.
- STEP_2, 3: reel 2 increment per tick, modulo 8.
- STEP_3, 5: reel 3 increment per tick, modulo 8.
- AUTO_STOP_TICKS, 64: ticks without a stop before the next reel auto-stops. Used only with SLOT_AUTO_STOP_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- spin  in  1  single-cycle pulse (already debounced): start a spin
- stop  in  1  single-cycle pulse (already debounced): stop the next spinning reel
- card_1  out  3  reel 1 symbol
- card_2  out  3  reel 2 symbol
- card_3  out  3  reel 3 symbol
- spinning  out  1  high while any reel is moving
- reel_stopped  out  3  bit i-1 high when reel i is frozen
- result_valid  out  1  one-cycle pulse; all cards final

Behaviour:
- Reset (async assert, sync release): state IDLE, tick counter 0, cards 0, spinning 0, reel_stopped 3'b111, result_valid 0. Reset mid-spin aborts immediately; no result_valid is issued.
- States: IDLE, SPIN_ALL, SPIN_23, SPIN_3, RESULT.
- IDLE: spin -> SPIN_ALL. Tick counter cleared, reel_stopped <= 000, spinning <= 1. Cards are not reset; the spin starts from the held values.
- SPIN_ALL: stop -> SPIN_23, reel_stopped <= 001.
- SPIN_23: stop -> SPIN_3, reel_stopped <= 011.
- SPIN_3: stop -> RESULT, reel_stopped <= 111, spinning <= 0.
- RESULT: result_valid = 1 for exactly this cycle; unconditionally -> IDLE.
- Tick counter runs 0..TICK_DIV-1 in the SPIN_* states and is held at 0 in IDLE/RESULT. A tick is the cycle the counter equals TICK_DIV-1.
- On a tick, each non-stopped reel updates card_i <= (card_i + STEP_i) mod 8 (3-bit wrap).
- Stop and tick in the same cycle: the reel being stopped does not advance; the other spinning reels do.
- Latency: stop sampled at edge n freezes the reel at edge n. In SPIN_3, result_valid is high in the cycle after edge n; IDLE is reached one cycle later.
- spin outside IDLE is ignored. stop in IDLE or RESULT is ignored. spin and stop together in IDLE: spin wins, stop is dropped.
- Cards hold their values from RESULT until the next tick of the next spin.

Optional Feature:
- Macro: SLOT_AUTO_STOP_EN.
- Defined: a tick-based idle counter is cleared on every stop and on entry to SPIN_ALL. When it reaches AUTO_STOP_TICKS in a SPIN_* state, it acts as an internal stop pulse (same transitions, same tick priority) and then clears.
- Undefined: no counter is instantiated; reels spin indefinitely until an external stop arrives.

Decomposition:
- Shared package slot_pkg:
  - SYMBOL_W = 3, NUM_REELS = 3.
  - State encodings for IDLE/SPIN_ALL/SPIN_23/SPIN_3/RESULT.
  - calculate_result also takes its card width from SYMBOL_W.
- One natural sub-module, reel_counter, instantiated three times:
  - inputs: clk, rst_n, enable (tick & ~stopped), STEP parameter.
  - output: 3-bit symbol.
- The FSM, tick divider and optional auto-stop counter stay in the top module.

Test Plan (TICK_DIV=4 for all scenarios):
- Reset: rst_n low mid-cycle -> cards 0/0/0, reel_stopped 111, spinning 0, result_valid 0, with no clock edge required.
- Basic spin: spin pulse, then 2 ticks (8 cycles) -> cards 2/6/2. Three stops spaced 4 cycles apart -> result_valid pulses once; final cards match the model (e.g. 3/9mod8=1/...) and are consistent with the frozen reels.
- Wrap: let all reels spin 8 ticks with no stop -> cards return to their start values (0/0/0 from reset).
- Collision: stop on a tick cycle in SPIN_ALL -> card_1 unchanged; card_2 and card_3 advance by 3 and 5.
- Ignored inputs: spin during SPIN_23 causes no state change. stop in IDLE leaves reel_stopped at 111. spin+stop together in IDLE -> SPIN_ALL with reel_stopped 000.
- SLOT_AUTO_STOP_EN with AUTO_STOP_TICKS=2: spin with no stops -> reels freeze at ticks 2, 4 and 6; result_valid follows, and reset mid-spin yields no pulse.
